proc_ctrl_sequencer: RTL and testbench
======================================

Name: proc_ctrl_sequencer

Overview:
- Multi-cycle control FSM for the 8-register, single-bus processor datapath.
- Latches a 16-bit instruction from `din` on `run`, then drives one-hot bus-source selects, register load enables, ALU operand/result enables and ALU op for 1–3 execute cycles.
- Pulses `done` on the final execute cycle.
- Replaces the fixed 3-step sequence with opcode-dependent sequencing: mv, mvi, add, sub, and, mvnz.

Parameters:
- IW, 16, instruction/data word width (fixed field layout below assumes 16).
- NREG, 8, number of general registers; one-hot enable width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns FSM to T0 and clears IR
- run  in  1  start request; sampled only in T0
- din  in  IW  instruction word (fetch, T0) / immediate (mvi, T1)
- g_zero  in  1  datapath G register == 0 flag
- ir_load  out  1  IR capture strobe (mirrors internal load)
- reg_in  out  NREG  one-hot register load enable
- reg_out  out  NREG  one-hot register-to-bus select
- din_out  out  1  din-to-bus select
- g_out  out  1  G-to-bus select
- a_in  out  1  load A from bus
- g_in  out  1  load G from ALU
- alu_op  out  2  00 add, 01 sub, 10 and, 11 reserved
- done  out  1  instruction-complete pulse
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Instruction fields:
  - Rx = IR[15:13]
  - Ry = IR[12:10]
  - op = IR[9:7]
  - IR[6:0] ignored
- Opcodes:
  - 000 mv
  - 001 mvi
  - 010 add
  - 011 sub
  - 100 and
  - 101 mvnz
  - 110/111 illegal
- States T0..T3 (2-bit). Reset (synchronous) → T0, IR=0.
- Outputs are combinational from state+IR. Every output not listed for a state is 0.
- Reset value of all outputs (T0 with run=0) = 0.
- T0:
  - ir_load = run.
  - If run=1, IR ← din at the edge and next = T1; else stay T0.
- T1:
  - mv: reg_out[Ry], reg_in[Rx], done; → T0.
  - mvi: din_out, reg_in[Rx], done; → T0. Immediate must be on din during T1.
  - mvnz: if g_zero=0, reg_out[Ry] and reg_in[Rx]; if g_zero=1, no enables. done in both cases; → T0. g_zero is sampled in T1.
  - add/sub/and: reg_out[Rx], a_in; → T2.
  - illegal: done, illegal, no enables; → T0.
- T2 (ALU ops only): reg_out[Ry], g_in, alu_op per opcode (add 00, sub 01, and 10); → T3.
- T3: g_out, reg_in[Rx], done; → T0.
- Latency from run-accept edge to done:
  - 1 cycle: mv, mvi, mvnz, illegal.
  - 3 cycles: ALU ops.
- Back-to-back: run held high in T0 after done fetches the next instruction immediately. There is no idle bubble beyond the T0 fetch cycle.
- Bus exclusivity invariant: at most one of {reg_out bits, din_out, g_out} is high in any cycle. reg_in is zero or one-hot.
- run is ignored in T1–T3. Deasserting it mid-instruction does not abort the instruction.
- Reset mid-instruction: next edge → T0. All outputs 0 in the following cycle. The IR write is suppressed.
- Rx==Ry is legal: add R3,R3 doubles R3, with no special casing.
- IR is held across T1–T3. Changes on din after fetch do not affect sequencing, except the mvi immediate.
- Unreachable state encodings → T0.

Test Plan:
- Reset/idle: reset=1 for 2 cycles with run=0 → all outputs 0, state stays T0. run=0 for 10 cycles → no ir_load, no done.
- mvi R2,#0x00A5: din=0x4080, run=1; next cycle din=0x00A5 → T1 has din_out=1, reg_in=8'b0000_0100, done=1. Next cycle is T0.
- add R1,R5: din=0x3500 accepted →
  - T1: reg_out=8'b0000_0010, a_in=1.
  - T2: reg_out=8'b0010_0000, g_in=1, alu_op=00.
  - T3: g_out=1, reg_in=8'b0000_0010, done=1.
  - done occurs exactly 3 cycles after accept.
- mvnz R0,R7 (din=0x1E80):
  - g_zero=1 in T1 → done=1, reg_in=0, reg_out=0.
  - Repeat with g_zero=0 → reg_out=8'b1000_0000, reg_in=8'b0000_0001.
- Illegal opcode din=0x0300 (op=110) → T1 illegal=1, done=1, all enables 0; returns to T0.
- Reset in T2 of a sub instruction → next cycle all outputs 0 and state T0. Then back-to-back mv, mvi, and with run held high → done pulses at the expected cycles (+1, +1, +3) and the bus-exclusivity assertion holds throughout.

Source files
------------

// File: rtl/proc_ctrl_sequencer_if.sv
// Control/datapath handshake bundle between the instruction sequencer and the single-bus datapath.
// The master side drives run/din/g_zero; the sequencer (slave) drives the bus and load strobes.
interface proc_ctrl_sequencer_if #(
   parameter int IW   = 16,
   parameter int NREG = 8
);
   logic            run;
   logic [IW-1:0]   din;
   logic            g_zero;
   logic            ir_load;
   logic [NREG-1:0] reg_in;
   logic [NREG-1:0] reg_out;
   logic            din_out;
   logic            g_out;
   logic            a_in;
   logic            g_in;
   logic [1:0]      alu_op;
   logic            done;
   logic            illegal;

   modport master (
      output run, din, g_zero,
      input  ir_load, reg_in, reg_out, din_out, g_out, a_in, g_in, alu_op, done, illegal
   );

   modport slave (
      input  run, din, g_zero,
      output ir_load, reg_in, reg_out, din_out, g_out, a_in, g_in, alu_op, done, illegal
   );
endinterface

// File: rtl/proc_ctrl_sequencer.sv
// Opcode-dependent multi-cycle control FSM for the 8-register single-bus datapath.
// Fetch in T0, then 1 execute cycle (mv/mvi/mvnz/illegal) or 3 (add/sub/and); outputs are Moore-ish from state+IR.
module proc_ctrl_sequencer #(
   parameter int IW   = 16,
   parameter int NREG = 8
) (
   input logic                 clk,
   input logic                 reset,
   proc_ctrl_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_MVNZ = 3'b101;

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_ir;
   logic [2:0]      w_rx;
   logic [2:0]      w_ry;
   logic [2:0]      w_op;
   logic            w_is_alu;
   logic [NREG-1:0] w_rx_oh;
   logic [NREG-1:0] w_ry_oh;
   logic            w_unused_ir;

   assign w_rx        = r_ir[15:13];
   assign w_ry        = r_ir[12:10];
   assign w_op        = r_ir[9:7];
   assign w_unused_ir = ^r_ir[6:0];
   assign w_is_alu    = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND);
   assign w_rx_oh     = NREG'(1) << w_rx;
   assign w_ry_oh     = NREG'(1) << w_ry;

   // Reset wins over the T0 fetch, so a run coinciding with reset never loads IR.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= T0;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == T0 && bus.run) begin
            r_ir <= bus.din;
         end
      end
   end

   always_comb begin
      w_next = T0;
      case (r_state)
         T0:      w_next = bus.run ? T1 : T0;
         T1:      w_next = w_is_alu ? T2 : T0;
         T2:      w_next = T3;
         T3:      w_next = T0;
         default: w_next = T0;
      endcase
   end

   always_comb begin
      bus.ir_load = 1'b0;
      bus.reg_in  = '0;
      bus.reg_out = '0;
      bus.din_out = 1'b0;
      bus.g_out   = 1'b0;
      bus.a_in    = 1'b0;
      bus.g_in    = 1'b0;
      bus.alu_op  = 2'b00;
      bus.done    = 1'b0;
      bus.illegal = 1'b0;
      case (r_state)
         T0: bus.ir_load = bus.run;
         T1: begin
            case (w_op)
               OP_MV: begin
                  bus.reg_out = w_ry_oh;
                  bus.reg_in  = w_rx_oh;
                  bus.done    = 1'b1;
               end
               OP_MVI: begin
                  bus.din_out = 1'b1;
                  bus.reg_in  = w_rx_oh;
                  bus.done    = 1'b1;
               end
               OP_MVNZ: begin
                  if (!bus.g_zero) begin
                     bus.reg_out = w_ry_oh;
                     bus.reg_in  = w_rx_oh;
                  end
                  bus.done = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND: begin
                  bus.reg_out = w_rx_oh;
                  bus.a_in    = 1'b1;
               end
               default: begin
                  bus.done    = 1'b1;
                  bus.illegal = 1'b1;
               end
            endcase
         end
         T2: begin
            bus.reg_out = w_ry_oh;
            bus.g_in    = 1'b1;
            case (w_op)
               OP_SUB:  bus.alu_op = 2'b01;
               OP_AND:  bus.alu_op = 2'b10;
               default: bus.alu_op = 2'b00;
            endcase
         end
         T3: begin
            bus.g_out  = 1'b1;
            bus.reg_in = w_rx_oh;
            bus.done   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_proc_ctrl_sequencer.sv
// Randomized self-checking bench for proc_ctrl_sequencer against an instruction-level reference model.
module tb_proc_ctrl_sequencer;
   localparam int IW   = 16;
   localparam int NREG = 8;

   typedef struct packed {
      logic            ir_load;
      logic [NREG-1:0] reg_in;
      logic [NREG-1:0] reg_out;
      logic            din_out;
      logic            g_out;
      logic            a_in;
      logic            g_in;
      logic [1:0]      alu_op;
      logic            done;
      logic            illegal;
   } out_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   out_t obs [4];
   int   obs_n;

   proc_ctrl_sequencer_if #(.IW(IW), .NREG(NREG)) bus ();

   proc_ctrl_sequencer #(.IW(IW), .NREG(NREG)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   a_bus_excl: assert property (@(negedge clk) disable iff (reset)
      $onehot0({bus.reg_out, bus.din_out, bus.g_out}) && $onehot0(bus.reg_in));

   function automatic out_t sample();
      out_t o;
      o.ir_load = bus.ir_load;
      o.reg_in  = bus.reg_in;
      o.reg_out = bus.reg_out;
      o.din_out = bus.din_out;
      o.g_out   = bus.g_out;
      o.a_in    = bus.a_in;
      o.g_in    = bus.g_in;
      o.alu_op  = bus.alu_op;
      o.done    = bus.done;
      o.illegal = bus.illegal;
      return o;
   endfunction

   function automatic bit is_alu(logic [15:0] ir);
      return ir[9:7] inside {3'd2, 3'd3, 3'd4};
   endfunction

   function automatic int latency(logic [15:0] ir);
      return is_alu(ir) ? 3 : 1;
   endfunction

   // Reference: what each cycle of an instruction does, from the instruction semantics.
   function automatic out_t model(logic [15:0] ir, int step, logic gz);
      out_t o  = '0;
      int   rx = int'(ir[15:13]);
      int   ry = int'(ir[12:10]);
      int   op = int'(ir[9:7]);
      if (step == 0) begin
         o.ir_load = 1'b1;
      end else if (is_alu(ir)) begin
         if (step == 1) begin
            o.reg_out[rx] = 1'b1;
            o.a_in        = 1'b1;
         end else if (step == 2) begin
            o.reg_out[ry] = 1'b1;
            o.g_in        = 1'b1;
            o.alu_op      = 2'(op - 2);
         end else begin
            o.g_out      = 1'b1;
            o.reg_in[rx] = 1'b1;
            o.done       = 1'b1;
         end
      end else begin
         o.done = 1'b1;
         if (op == 0 || (op == 5 && !gz)) begin
            o.reg_out[ry] = 1'b1;
            o.reg_in[rx]  = 1'b1;
         end else if (op == 1) begin
            o.din_out    = 1'b1;
            o.reg_in[rx] = 1'b1;
         end else if (op != 5) begin
            o.illegal = 1'b1;
         end
      end
      return o;
   endfunction

   task automatic tick(input logic rst, input logic rn, input logic [15:0] d, input logic gz,
                       output out_t got);
      @(posedge clk);
      #1;
      reset      = rst;
      bus.run    = rn;
      bus.din    = d;
      bus.g_zero = gz;
      #1;
      got = sample();
   endtask

   // Drives one instruction: fetch cycle plus its execute cycles; results land in obs[].
   task automatic issue(input logic [15:0] ir, input logic [15:0] imm, input logic gz, input bit hold);
      out_t g;
      obs_n = latency(ir);
      tick(1'b0, 1'b1, ir, 1'($urandom), g);
      obs[0] = g;
      for (int s = 1; s <= obs_n; s++) begin
         tick(1'b0, hold ? 1'b1 : 1'($urandom), (s == 1) ? imm : 16'($urandom),
              (s == 1) ? gz : 1'($urandom), g);
         obs[s] = g;
      end
   endtask

   task automatic test_reset();
      out_t g;
      tick(1'b1, 1'b0, 16'h0000, 1'b0, g);
      tick(1'b1, 1'b0, 16'h0000, 1'b0, g);
      checks++;
      if (g !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 0", g);
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0, 16'($urandom), 1'($urandom), g);
         checks++;
         if (g !== '0) begin
            errors++;
            $display("FAIL idle cycle %0d got %h exp 0", i, g);
         end
      end
   endtask

   task automatic test_mvi();
      out_t e;
      issue(16'h4080, 16'h00A5, 1'b0, 1'b0);
      for (int s = 0; s <= obs_n; s++) begin
         e = model(16'h4080, s, 1'b0);
         checks++;
         if (obs[s] !== e) begin
            errors++;
            $display("FAIL mvi step %0d got %h exp %h", s, obs[s], e);
         end
      end
      checks++;
      if (obs[1].reg_in !== 8'b0000_0100 || obs[1].din_out !== 1'b1) begin
         errors++;
         $display("FAIL mvi_r2 reg_in %b din_out %b exp 00000100 1", obs[1].reg_in, obs[1].din_out);
      end
   endtask

   task automatic test_add();
      out_t e;
      issue(16'h3500, 16'h1234, 1'b1, 1'b0);
      for (int s = 0; s <= obs_n; s++) begin
         e = model(16'h3500, s, 1'b1);
         checks++;
         if (obs[s] !== e) begin
            errors++;
            $display("FAIL add step %0d got %h exp %h", s, obs[s], e);
         end
      end
      checks++;
      if (obs[1].reg_out !== 8'b0000_0010 || obs[2].reg_out !== 8'b0010_0000 || obs[3].done !== 1'b1) begin
         errors++;
         $display("FAIL add_r1_r5 t1 %b t2 %b t3done %b", obs[1].reg_out, obs[2].reg_out, obs[3].done);
      end
   endtask

   task automatic test_mvnz();
      out_t e;
      for (int k = 0; k < 2; k++) begin
         issue(16'h1E80, 16'h0000, (k == 0), 1'b0);
         e = model(16'h1E80, 1, (k == 0));
         checks++;
         if (obs[1] !== e) begin
            errors++;
            $display("FAIL mvnz gz=%0d got %h exp %h", (k == 0), obs[1], e);
         end
      end
      checks++;
      if (obs[1].reg_out !== 8'b1000_0000 || obs[1].reg_in !== 8'b0000_0001) begin
         errors++;
         $display("FAIL mvnz_r0_r7 reg_out %b reg_in %b", obs[1].reg_out, obs[1].reg_in);
      end
   endtask

   task automatic test_illegal();
      out_t e;
      out_t g;
      issue(16'h0300, 16'hFFFF, 1'b0, 1'b0);
      e = model(16'h0300, 1, 1'b0);
      checks++;
      if (obs[1] !== e) begin
         errors++;
         $display("FAIL illegal got %h exp %h", obs[1], e);
      end
      tick(1'b0, 1'b0, 16'h0000, 1'b0, g);
      checks++;
      if (g !== '0) begin
         errors++;
         $display("FAIL illegal_return got %h exp 0", g);
      end
   endtask

   task automatic test_reset_mid();
      out_t g;
      out_t e;
      logic [15:0] ir = {3'd4, 3'd6, 3'b011, 7'd0};
      tick(1'b0, 1'b1, ir, 1'b0, g);
      tick(1'b0, 1'b0, 16'h0000, 1'b0, g);
      tick(1'b1, 1'b1, 16'h2080, 1'b0, g);
      e = model(ir, 2, 1'b0);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL reset_mid_t2 got %h exp %h", g, e);
      end
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b0, 16'h0000, 1'b0, g);
         checks++;
         if (g !== '0) begin
            errors++;
            $display("FAIL reset_mid_after %0d got %h exp 0", i, g);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] prog [3];
      int          lat_exp [3];
      out_t        e;
      int          first_done;
      prog[0] = {3'd3, 3'd6, 3'b000, 7'd0};
      prog[1] = {3'd5, 3'd0, 3'b001, 7'd0};
      prog[2] = {3'd2, 3'd2, 3'b100, 7'd0};
      lat_exp = '{1, 1, 3};
      for (int n = 0; n < 3; n++) begin
         issue(prog[n], 16'($urandom), 1'($urandom), 1'b1);
         first_done = -1;
         for (int s = 0; s <= obs_n; s++) begin
            e = model(prog[n], s, 1'b0);
            if (first_done < 0 && obs[s].done === 1'b1) first_done = s;
            checks++;
            if (obs[s] !== e) begin
               errors++;
               $display("FAIL b2b instr %0d step %0d got %h exp %h", n, s, obs[s], e);
            end
         end
         checks++;
         if (first_done != lat_exp[n]) begin
            errors++;
            $display("FAIL b2b_latency instr %0d got %0d exp %0d", n, first_done, lat_exp[n]);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] ir;
      logic        gz;
      out_t        e;
      for (int n = 0; n < 40; n++) begin
         ir = 16'($urandom);
         gz = 1'($urandom);
         issue(ir, 16'($urandom), gz, 1'($urandom));
         for (int s = 0; s <= obs_n; s++) begin
            e = model(ir, s, gz);
            checks++;
            if (obs[s] !== e) begin
               errors++;
               $display("FAIL random ir %h step %0d got %h exp %h", ir, s, obs[s], e);
            end
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      bus.run    = 1'b0;
      bus.din    = '0;
      bus.g_zero = 1'b0;
      test_reset();
      test_mvi();
      test_add();
      test_mvnz();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
